// File: rtl/mux_4x1.sv
// Four-input selector with a combinational output plus a registered copy
// (data, select and a select-change pulse) for clocked consumers.
module mux_4x1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] l,
    input  logic [WIDTH-1:0] m,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       sel_q,
    output logic             sel_chg
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_reg_q, sel_reg_d;
    logic             chg_q, chg_d;

    // An X/Z select matches no item and leaves the default X on out.
    always_comb begin
        // NOTE: default assigned before the case so no path leaves out unassigned (no latch).
        out = 'x;
        case (sel)
            2'b00: out = j;
            2'b01: out = k;
            2'b10: out = l;
            2'b11: out = m;
            default: ;
        endcase
    end

    always_comb begin
        data_d    = out;
        sel_reg_d = sel;
        chg_d     = (sel != sel_reg_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            sel_reg_q <= 2'b00;
            chg_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so chg_d sees the pre-edge sel_reg_q, not the new one.
            data_q    <= data_d;
            sel_reg_q <= sel_reg_d;
            chg_q     <= chg_d;
        end
    end

    assign out_q   = data_q;
    assign sel_q   = sel_reg_q;
    assign sel_chg = chg_q;

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: table-driven combinational vectors plus a
// scoreboarded clocked sequence covering reset release and mid-cycle reset.
module tb_mux_4x1;

    localparam int W = 4;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  j, k, l, m;
    logic [1:0]    sel;
    logic [W-1:0]  out, out_q;
    logic [1:0]    sel_q;
    logic          sel_chg;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] j, k, l, m;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] out_q;
        logic [1:0]   sel_q;
        logic         chg;
    } reg_exp_t;

    reg_exp_t   sb[$];
    logic [1:0] m_sel_q;

    mux_4x1 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .j       (j),
        .k       (k),
        .l       (l),
        .m       (m),
        .sel     (sel),
        .out     (out),
        .out_q   (out_q),
        .sel_q   (sel_q),
        .sel_chg (sel_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mux_ref(input logic [1:0] s,
                                             input logic [W-1:0] a, b, c, d);
        case (s)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return c;
            default: return d;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one clocked transaction at the falling edge, predict the registered
    // result, then compare it just after the next rising edge.
    task automatic step(input logic [1:0] s, input logic [W-1:0] a, b, c, d);
        reg_exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        sel = s; j = a; k = b; l = c; m = d;
        e.out_q = mux_ref(s, a, b, c, d);
        e.sel_q = s;
        e.chg   = (s != m_sel_q);
        sb.push_back(e);
        m_sel_q = s;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("out_q", 32'(out_q), 32'(e.out_q));
            check("sel_q", 32'(sel_q), 32'(e.sel_q));
            check("sel_chg", 32'(sel_chg), 32'(e.chg));
        end
        check("out_comb", 32'(out), 32'(mux_ref(s, a, b, c, d)));
    endtask

    initial begin
        vec_t vecs[12];
        logic [1:0] s;

        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        sel = 2'b00; j = '0; k = '0; l = '0; m = '0;
        m_sel_q = 2'b00;

        vecs[0]  = '{2'b00, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
        vecs[1]  = '{2'b01, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF};
        vecs[2]  = '{2'b10, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0};
        vecs[3]  = '{2'b11, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[4]  = '{2'b00, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        vecs[5]  = '{2'b01, 4'h1, 4'h2, 4'h4, 4'h8, 4'h2};
        vecs[6]  = '{2'b10, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4};
        vecs[7]  = '{2'b11, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8};
        // Only the non-selected inputs move; out must stay at l.
        vecs[8]  = '{2'b10, 4'h0, 4'h0, 4'hA, 4'h0, 4'hA};
        vecs[9]  = '{2'b10, 4'hF, 4'h0, 4'hA, 4'h0, 4'hA};
        vecs[10] = '{2'b10, 4'hF, 4'hF, 4'hA, 4'hF, 4'hA};
        vecs[11] = '{2'b10, 4'h5, 4'hC, 4'hA, 4'h3, 4'hA};

        // Combinational path exercised while reset is held.
        #2;
        check("rst_out_q", 32'(out_q), 32'h0);
        check("rst_sel_q", 32'(sel_q), 32'h0);
        check("rst_sel_chg", 32'(sel_chg), 32'h0);
        for (int i = 0; i < 12; i++) begin
            sel = vecs[i].sel; j = vecs[i].j; k = vecs[i].k;
            l = vecs[i].l;     m = vecs[i].m;
            #5;
            check($sformatf("comb_vec%0d", i), 32'(out), 32'(vecs[i].exp));
        end

        sel = 2'b11; m = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("hold_rst_out_q", 32'(out_q), 32'h0);
        check("hold_rst_sel_q", 32'(sel_q), 32'h0);
        check("hold_rst_sel_chg", 32'(sel_chg), 32'h0);

        // Release with sel=11: first edge compares against reset value 00.
        step(2'b11, 4'h0, 4'h0, 4'h0, 4'hF);
        step(2'b11, 4'h0, 4'h0, 4'h0, 4'hF);

        // Select changing every cycle keeps sel_chg high.
        for (int i = 0; i < 8; i++) begin
            s = 2'(i);
            step(s, 4'(i + 1), 4'(i + 3), 4'(i + 7), 4'(i + 11));
        end
        for (int i = 0; i < 24; i++) begin
            s = 2'($urandom_range(0, 3));
            step(s, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        step(2'b10, 4'h1, 4'h2, 4'h6, 4'h8);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_q", 32'(out_q), 32'h0);
        check("midrst_sel_q", 32'(sel_q), 32'h0);
        check("midrst_sel_chg", 32'(sel_chg), 32'h0);
        check("midrst_out", 32'(out), 32'h6);
        m_sel_q = 2'b00;

        // Release with sel=00: no pulse, then a change to 01 pulses.
        step(2'b00, 4'h9, 4'h3, 4'h0, 4'h0);
        step(2'b01, 4'h9, 4'h3, 4'h0, 4'h0);
        step(2'b01, 4'h9, 4'h3, 4'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
